delay_sum_beamformer: RTL and testbench

//  Multi-channel delay-and-sum core. Sits after the per-mic i2s_to_pcm receivers.

---
 rtl/delay_sum_beamformer.sv | 115 +++++++++++
 tb/tb_delay_sum_beamformer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/delay_sum_beamformer.sv
// Delay-and-sum beamformer core.
// Each channel keeps a circular history buffer and has a programmable integer
// sample delay. The delayed samples of all channels are added at full
// precision into one registered beam sample. A fill counter masks history
// that has not been written since reset.
module delay_sum_beamformer #(
  parameter  int NUM_CHANNELS = 2,
  parameter  int SAMPLE_BITS  = 8,
  parameter  int MAX_DELAY    = 10,
  localparam int CH_BITS      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int DLY_BITS     = $clog2(MAX_DELAY + 1),
  localparam int SUM_BITS     = SAMPLE_BITS + $clog2(NUM_CHANNELS)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  input  logic [NUM_CHANNELS*SAMPLE_BITS-1:0]  in_data,
  input  logic                                 cfg_we,
  input  logic [CH_BITS-1:0]                   cfg_ch,
  input  logic [DLY_BITS-1:0]                  cfg_delay,
  output logic                                 out_valid,
  output logic [SUM_BITS-1:0]                  out_sum,
  output logic                                 out_primed
);

  localparam int PTR_BITS = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

  logic [SAMPLE_BITS-1:0] r_ram [NUM_CHANNELS][MAX_DELAY];
  logic [DLY_BITS-1:0]    r_delay [NUM_CHANNELS];
  logic [PTR_BITS-1:0]    r_wr_ptr;
  logic [DLY_BITS-1:0]    r_fill;
  logic                   r_out_valid;
  logic [SUM_BITS-1:0]    r_out_sum;
  logic                   r_out_primed;

  logic [SUM_BITS-1:0]    w_sum;
  logic [SAMPLE_BITS-1:0] w_term;
  logic [DLY_BITS-1:0]    w_ptr_ext;
  logic [DLY_BITS-1:0]    w_rd_idx;
  logic [PTR_BITS-1:0]    w_ptr_nxt;
  logic [DLY_BITS-1:0]    w_fill_nxt;
  logic [DLY_BITS-1:0]    w_cfg_dly;

  // Select each channel's delayed term (bypass, buffered, or masked) and sum them
  always_comb begin
    w_sum     = '0;
    w_term    = '0;
    w_rd_idx  = '0;
    w_ptr_ext = DLY_BITS'(r_wr_ptr);
    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
      w_term = in_data[k*SAMPLE_BITS +: SAMPLE_BITS];
      if (r_delay[k] != '0) begin
        // Modular read index; a delay equal to MAX_DELAY lands on the slot
        // about to be overwritten, so its old value is read this cycle.
        w_rd_idx = (w_ptr_ext >= r_delay[k]) ? (w_ptr_ext - r_delay[k])
                                              : (w_ptr_ext + DLY_BITS'(MAX_DELAY) - r_delay[k]);
        w_term   = (r_delay[k] > r_fill) ? '0 : r_ram[k][PTR_BITS'(w_rd_idx)];
      end
      w_sum = w_sum + SUM_BITS'(signed'(w_term));
    end
  end

  // Pointer wrap, saturating fill and clamped config delay
  always_comb begin
    w_ptr_nxt  = (r_wr_ptr == PTR_BITS'(MAX_DELAY - 1)) ? '0 : r_wr_ptr + PTR_BITS'(1);
    w_fill_nxt = (r_fill == DLY_BITS'(MAX_DELAY)) ? r_fill : r_fill + DLY_BITS'(1);
    w_cfg_dly  = (cfg_delay > DLY_BITS'(MAX_DELAY)) ? DLY_BITS'(MAX_DELAY) : cfg_delay;
  end

  // History buffer write; contents are never cleared, the fill counter masks them
  always_ff @(posedge clk) begin
    if (in_valid && !reset) begin
      for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
        r_ram[k][r_wr_ptr] <= in_data[k*SAMPLE_BITS +: SAMPLE_BITS];
      end
    end
  end

  // Control state, delay registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
        r_delay[k] <= '0;
      end
      r_wr_ptr     <= '0;
      r_fill       <= '0;
      r_out_valid  <= 1'b0;
      r_out_sum    <= '0;
      r_out_primed <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_out_sum <= w_sum;
        r_wr_ptr  <= w_ptr_nxt;
        r_fill    <= w_fill_nxt;
        if (w_fill_nxt == DLY_BITS'(MAX_DELAY)) begin
          r_out_primed <= 1'b1;
        end
      end
      // Out-of-range channel indices match no register and are dropped
      if (cfg_we) begin
        for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
          if (cfg_ch == CH_BITS'(k)) begin
            r_delay[k] <= w_cfg_dly;
          end
        end
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_sum    = r_out_sum;
  assign out_primed = r_out_primed;

endmodule

// File: tb/tb_delay_sum_beamformer.sv
// Self-checking bench for delay_sum_beamformer: directed scenarios with
// literal expectations plus a randomized run, all compared every cycle
// against a queue-based reference model of delay-and-sum.
module tb_delay_sum_beamformer;

  localparam int NCH  = 3;
  localparam int SB   = 8;
  localparam int MD   = 10;
  localparam int CHB  = 2;
  localparam int DLB  = 4;
  localparam int SUMB = 10;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                in_valid = 1'b0;
  logic [NCH*SB-1:0]   in_data = '0;
  logic                cfg_we = 1'b0;
  logic [CHB-1:0]      cfg_ch = '0;
  logic [DLB-1:0]      cfg_delay = '0;
  logic                out_valid;
  logic [SUMB-1:0]     out_sum;
  logic                out_primed;

  delay_sum_beamformer #(
    .NUM_CHANNELS (NCH),
    .SAMPLE_BITS  (SB),
    .MAX_DELAY    (MD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_delay  (cfg_delay),
    .out_valid  (out_valid),
    .out_sum    (out_sum),
    .out_primed (out_primed)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model state: history since reset, delays, sample count
  int hist [NCH][$];
  int mdly [NCH];
  int nsamp = 0;
  int m_sum = 0;
  bit m_primed = 1'b0;
  bit exp_valid = 1'b0;
  int exp_sum = 0;
  bit exp_primed = 1'b0;

  function automatic logic [NCH*SB-1:0] pk(input int a, input int b, input int c);
    logic [SB-1:0] xa, xb, xc;
    xa = a[SB-1:0];
    xb = b[SB-1:0];
    xc = c[SB-1:0];
    return {xc, xb, xa};
  endfunction

  // One clock cycle: apply inputs, advance the model, publish expectations
  task automatic cyc(input bit rst, input bit vld, input logic [NCH*SB-1:0] d,
                     input bit we, input int ch, input int dly);
    int s, t, x;
    logic [SB-1:0] xs;
    bit nv;
    @(negedge clk);
    reset     = rst;
    in_valid  = vld;
    in_data   = d;
    cfg_we    = we;
    cfg_ch    = ch[CHB-1:0];
    cfg_delay = dly[DLB-1:0];
    nv = 1'b0;
    if (rst) begin
      m_sum = 0;
      m_primed = 1'b0;
      nsamp = 0;
      for (int k = 0; k < NCH; k++) begin
        mdly[k] = 0;
        hist[k].delete();
      end
    end else begin
      nv = vld;
      if (vld) begin
        s = 0;
        for (int k = 0; k < NCH; k++) begin
          xs = d[k*SB +: SB];
          x = int'($signed(xs));
          if (mdly[k] == 0) t = x;
          else if (mdly[k] > nsamp) t = 0;
          else t = hist[k][hist[k].size() - mdly[k]];
          s += t;
        end
        for (int k = 0; k < NCH; k++) begin
          xs = d[k*SB +: SB];
          hist[k].push_back(int'($signed(xs)));
          if (hist[k].size() > MD) void'(hist[k].pop_front());
        end
        nsamp++;
        m_sum = s;
        if (nsamp >= MD) m_primed = 1'b1;
      end
      if (we && ch < NCH) mdly[ch] = (dly > MD) ? MD : dly;
    end
    @(posedge clk);
    exp_valid  = nv;
    exp_sum    = m_sum;
    exp_primed = m_primed;
  endtask

  task automatic lit(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, expv);
    end
  endtask

  function automatic int sum_now();
    return int'($signed(out_sum));
  endfunction

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      logic [SUMB-1:0] es;
      es = exp_sum[SUMB-1:0];
      total++;
      if (out_valid !== exp_valid) begin
        bad++;
        $display("FAIL out_valid @%0t: got %b want %b", $time, out_valid, exp_valid);
      end
      total++;
      if (out_sum !== es) begin
        bad++;
        $display("FAIL out_sum @%0t: got %0d want %0d", $time, $signed(out_sum), exp_sum);
      end
      total++;
      if (out_primed !== exp_primed) begin
        bad++;
        $display("FAIL out_primed @%0t: got %b want %b", $time, out_primed, exp_primed);
      end
    end
  end

  initial begin
    // Reset held two cycles, with a sample offered during reset
    cyc(1, 0, '0, 0, 0, 0);
    chk_en = 1'b1;
    cyc(1, 1, pk(50, 50, 50), 0, 0, 0);
    #1;
    lit("rst_valid", int'(out_valid), 0);
    lit("rst_sum", sum_now(), 0);
    lit("rst_primed", int'(out_primed), 0);

    // Bypass sums
    cyc(0, 1, pk(5, -3, 0), 0, 0, 0);     #1; lit("byp_small", sum_now(), 2);
    lit("byp_valid", int'(out_valid), 1);
    cyc(0, 1, pk(127, 127, 0), 0, 0, 0);  #1; lit("byp_max", sum_now(), 254);
    cyc(0, 1, pk(-128, -128, 0), 0, 0, 0); #1; lit("byp_min", sum_now(), -256);
    cyc(0, 0, '0, 0, 0, 0);               #1; lit("pulse_low", int'(out_valid), 0);
    lit("hold_sum", sum_now(), -256);

    // Delay with fill masking
    cyc(1, 0, '0, 0, 0, 0);
    cyc(0, 0, '0, 1, 0, 3);
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 1, pk(10*i, 0, 0), 0, 0, 0);
      #1;
      lit("dly3", sum_now(), (i <= 3) ? 0 : 10*(i-3));
    end

    // Clamp, wrap and priming
    cyc(1, 0, '0, 0, 0, 0);
    cyc(0, 0, '0, 1, 0, 15);
    for (int i = 0; i < 25; i++) begin
      cyc(0, 1, pk((i == 0) ? 7 : 0, 0, 0), 0, 0, 0);
      #1;
      if (i == 8)  lit("primed_before", int'(out_primed), 0);
      if (i == 9)  lit("primed_after", int'(out_primed), 1);
      if (i == 10) lit("impulse_d10", sum_now(), 7);
      if (i == 20) lit("wrap_zero", sum_now(), 0);
    end

    // Config race and ignored channel
    cyc(1, 0, '0, 0, 0, 0);
    cyc(0, 1, pk(9, 0, 0), 1, 0, 2); #1; lit("race_old", sum_now(), 9);
    cyc(0, 1, pk(1, 0, 0), 0, 0, 0); #1; lit("race_mask", sum_now(), 0);
    cyc(0, 1, pk(2, 0, 0), 0, 0, 0); #1; lit("race_new", sum_now(), 9);
    cyc(0, 1, pk(3, 0, 0), 1, 3, 5); #1; lit("race_d2", sum_now(), 1);
    cyc(0, 1, pk(4, 0, 0), 0, 0, 0); #1; lit("ch3_ignored", sum_now(), 2);

    // Reset mid-stream must not leak stale history
    cyc(1, 0, '0, 0, 0, 0);
    cyc(0, 0, '0, 1, 0, 3);
    for (int i = 0; i < 6; i++) cyc(0, 1, pk(100, 0, 0), 0, 0, 0);
    cyc(1, 1, pk(100, 0, 0), 0, 0, 0); #1; lit("midrst_drop", int'(out_valid), 0);
    cyc(0, 0, '0, 1, 0, 3);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, '0, 0, 0, 0);
      #1;
      lit("midrst_zero", sum_now(), 0);
    end

    // Randomized run against the model
    cyc(1, 0, '0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7),
          NCH*SB'($urandom), ($urandom_range(0, 9) == 0),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
